// File: rtl/mem_pkg.sv
// Shared constants and types for the main memory responder and its requesters.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } mem_state_e;

    localparam int unsigned WordSize         = 4;
    localparam logic [31:0] DefaultStartAddr = 32'h8002_0000;

    localparam logic [31:0] SizeWord1  = 32'd4;
    localparam logic [31:0] SizeWord4  = 32'd16;
    localparam logic [31:0] SizeWord8  = 32'd32;
    localparam logic [31:0] SizeWord16 = 32'd64;

    function automatic logic size_legal(input logic [31:0] size);
        return (size == SizeWord1) || (size == SizeWord4) ||
               (size == SizeWord8) || (size == SizeWord16);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Only the read register is reset; the storage itself is never cleared.
module mem_array #(
    parameter int unsigned depth_words = 1024,
    parameter int unsigned addr_width  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [depth_words];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds its last value on cycles without a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory.sv
// Word-organised main memory: request decode, range check, beat counter and burst FSM
// in front of a single-port RAM. Beat 0 of every request is serviced on the accepting edge.
module main_memory
    import mem_pkg::*;
#(
    parameter logic [31:0] start_addr  = DefaultStartAddr,
    parameter int unsigned depth_words = 1024,
    parameter int unsigned word_size   = WordSize
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] address,
    input  logic        rw,
    input  logic [31:0] access_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        error
);

    localparam int unsigned AddrW = $clog2(depth_words);

    mem_state_e       state_q;
    logic [AddrW-1:0] idx_q;
    logic [4:0]       cnt_q;
    logic             data_valid_q;
    logic             error_q;

    logic [31:0]      offset;
    logic [31:0]      req_index;
    logic [31:0]      req_beats;
    logic             req_bad;
    logic             accept;
    logic             ram_en;
    logic             ram_we;
    logic [AddrW-1:0] ram_addr;

    always_comb begin
        offset    = address - start_addr;
        req_index = offset / word_size;
        req_beats = access_size / word_size;
        // 33-bit sum so a huge index cannot wrap past the depth check.
        req_bad   = ((address % word_size) != 32'd0) ||
                    !size_legal(access_size) ||
                    (address < start_addr) ||
                    (({1'b0, req_index} + {1'b0, req_beats}) > 33'(depth_words));
        accept    = (state_q == StIdle) && enable && !req_bad && !reset;

        ram_en    = accept || (state_q != StIdle);
        ram_we    = (state_q == StIdle) ? !rw : (state_q == StWrite);
        ram_addr  = (state_q == StIdle) ? req_index[AddrW-1:0] : idx_q;
    end

    mem_array #(
        .depth_words (depth_words),
        .addr_width  (AddrW)
    ) u_mem_array (
        .clock (clock),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_in),
        .rdata (data_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (enable && req_bad) begin
                        error_q <= 1'b1;
                    end else if (accept) begin
                        data_valid_q <= rw;
                        cnt_q        <= 5'(req_beats - 32'd1);
                        if (req_beats > 32'd1) begin
                            state_q <= rw ? StRead : StWrite;
                            idx_q   <= req_index[AddrW-1:0] + AddrW'(1);
                        end
                    end
                end
                StRead, StWrite: begin
                    data_valid_q <= (state_q == StRead);
                    idx_q        <= idx_q + AddrW'(1);
                    cnt_q        <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_valid = data_valid_q;
    assign error      = error_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/main_memory.md
# main_memory

Word-organised main memory that is the responder end of the fetch/memory request interface. It sits behind the fetch stage and, later, the memory stage. It accepts one request per cycle of address, rw and access_size. It returns read data one word per cycle with single-cycle latency, and absorbs write bursts. Single-word reads complete without stalling, so the memory sustains one fetch per cycle.

## Interface
Parameters:
- start_addr, 32'h80020000, byte address mapped to word 0
- depth_words, 1024, number of 32-bit words stored (4 KB default)
- word_size, 4, bytes per word

Ports:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears control state
- enable  in  1  request strobe; sampled only when busy=0
- address  in  32  byte address of first word of the request
- rw  in  1  1=read, 0=write
- access_size  in  32  request length in bytes; legal values 4, 16, 32, 64 (1/4/8/16 words)
- data_in  in  32  write data, one word per beat
- data_out  out  32  read data, registered
- data_valid  out  1  data_out holds a read beat this cycle
- busy  out  1  burst in progress; enable ignored while high
- error  out  1  one-cycle pulse when a request is rejected

## Operation
- States: IDLE, READ, WRITE; busy=1 exactly when state≠IDLE.
- Request acceptance: enable=1 and busy=0 at edge N.
  - Latch index = (address − start_addr)/4, beats = access_size/4, rw.
- Rejection: any of these causes error=1 for the cycle after edge N, no memory access, and state stays IDLE:
  - address[1:0]≠0
  - access_size not in {4,16,32,64}
  - address < start_addr
  - index+beats > depth_words
- No wrap-around: bursts are linear and must fit entirely.
- Read, beat k (k=0..beats−1):
  - At edge N+k: data_out<=mem[index+k], data_valid<=1.
  - State is READ after edges N..N+beats−2 and IDLE after edge N+beats−1.
  - beats=1: state never leaves IDLE.
- Write, beat k:
  - At edge N+k: mem[index+k]<=data_in.
  - Beat 0 data is presented in the same cycle as the request.
  - State sequence and busy are identical to a read. data_valid stays 0.
- data_valid deasserts on any edge with no read beat; data_out holds its last value.
- Counter: 5-bit remaining-beats counter, decremented per beat; leave the busy state when it reaches 1 at a beat edge.
- Simultaneous enable with busy=1: ignored entirely, no error.
- The next request may be accepted at edge N+beats, back-to-back with the previous burst.

## Timing
- Read latency: data_valid high in the cycle following the accepting edge.
- busy high for beats−1 cycles: following edges N..N+beats−2.
- error is a one-cycle pulse following the rejecting edge.
- Reset values: data_out=0, data_valid=0, busy=0, error=0, state=IDLE, counter=0.
- Reset mid-burst aborts immediately; remaining beats are never issued or written. Words already written stay written.
- Memory array contents are not reset. The bench preloads them through a backdoor task.

## Structure
- Shared package mem_pkg holds:
  - state enum (IDLE/READ/WRITE)
  - legal access_size constants (4,16,32,64)
  - word_size
  - default start_addr
- fetch must reuse these constants.
- Sub-module mem_array: single-port synchronous word RAM (depth_words×32, one read or write per clock, registered read). main_memory contains only decode, range check, beat counter and FSM.

## Test plan
- Single-word read stream: preload mem[0..3]=A0..A3; requests at 0x80020000, +4, +8, +C on consecutive cycles, rw=1, size 4 -> data_valid held high 4 cycles, data_out A0..A3, busy never high.
- 8-word read burst at 0x80020010 -> busy high 7 cycles, 8 consecutive valid beats mem[4..11]; an enable during busy is ignored; a request on the edge after busy falls is accepted.
- 4-word write at 0x80020040 with data 11,22,33,44 on consecutive cycles, then 4-word read at the same address -> 11,22,33,44, no error.
- Rejections -> one-cycle error each, no data_valid, no memory change:
  - address 0x80020002
  - access_size 8
  - address 0x8001FFFC
  - 16-word burst at start_addr+4*1016 (overruns depth 1024)
- Reset asserted asynchronously on the third beat of a 16-word write -> outputs zero immediately; words 0–1 of the burst written, words 2–15 unchanged; a subsequent read returns the old contents for those words.
